// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared defaults, address type and port slicing helper for reg_file_mp
package reg_file_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int REG_ZERO  = 0;

    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

    // Bit offset of port `port` inside a flattened bus of `width`-bit lanes.
    function automatic int port_slice(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - per-register busy bits set by issue, cleared by final writeback
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_WR = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_WR-1:0]    we,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic [NUM_WR-1:0]    wr_clr,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    output logic [NREGS-1:0]     busy,
    output logic                 any_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        // Later ports overwrite earlier ones, so the highest writer decides the clear.
        for (int j = 0; j < NUM_WR; j++) begin
            if (we[j] && wr_addr[port_slice(j, AW) +: AW] != AW'(REG_ZERO)) begin
                busy_d[wr_addr[port_slice(j, AW) +: AW]] =
                    wr_clr[j] ? 1'b0 : busy_q[wr_addr[port_slice(j, AW) +: AW]];
            end
        end
        // A new producer supersedes any writeback landing in the same cycle.
        if (issue_valid && issue_rd != AW'(REG_ZERO)) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign any_busy = |busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with x0 hardwired to zero and busy scoreboard
// Optional same-cycle write-to-read forwarding under `REG_FILE_BYPASS_EN.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_RD*AW-1:0]   rs_addr,
    output logic [NUM_RD*XLEN-1:0] rs_data,
    output logic [NUM_RD-1:0]      rs_busy,
    input  logic [NUM_WR-1:0]      we,
    input  logic [NUM_WR*AW-1:0]   wr_addr,
    input  logic [NUM_WR*XLEN-1:0] wr_data,
    input  logic [NUM_WR-1:0]      wr_clr,
    input  logic                   issue_valid,
    input  logic [AW-1:0]          issue_rd,
    output logic                   any_busy
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy;

    reg_file_scoreboard #(
        .NREGS  (NREGS),
        .NUM_WR (NUM_WR),
        .AW     (AW)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .we          (we),
        .wr_addr     (wr_addr),
        .wr_clr      (wr_clr),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy        (busy),
        .any_busy    (any_busy)
    );

    // Ascending port order lets the highest-index writer win on address collisions.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (we[j] && wr_addr[port_slice(j, AW) +: AW] != AW'(REG_ZERO)) begin
                regs_d[wr_addr[port_slice(j, AW) +: AW]] = wr_data[port_slice(j, XLEN) +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef REG_FILE_BYPASS_EN
    logic [NUM_RD-1:0] byp_hit;
`endif

    // Entry 0 is never written and bit 0 of busy is never set, so x0 reads as zero/idle.
    always_comb begin
        rs_data = '0;
        rs_busy = '0;
`ifdef REG_FILE_BYPASS_EN
        byp_hit = '0;
`endif
        for (int i = 0; i < NUM_RD; i++) begin
            rs_data[port_slice(i, XLEN) +: XLEN] = regs_q[rs_addr[port_slice(i, AW) +: AW]];
            rs_busy[i] = busy[rs_addr[port_slice(i, AW) +: AW]];
`ifdef REG_FILE_BYPASS_EN
            if (rst_n && rs_addr[port_slice(i, AW) +: AW] != AW'(REG_ZERO)) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (we[j] && wr_addr[port_slice(j, AW) +: AW] == rs_addr[port_slice(i, AW) +: AW]) begin
                        byp_hit[i] = 1'b1;
                        rs_data[port_slice(i, XLEN) +: XLEN] = wr_data[port_slice(j, XLEN) +: XLEN];
                        rs_busy[i] = wr_clr[j] ? 1'b0 : busy[rs_addr[port_slice(i, AW) +: AW]];
                    end
                end
                if (byp_hit[i] && issue_valid && issue_rd == rs_addr[port_slice(i, AW) +: AW]) begin
                    rs_busy[i] = 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the RISC-V core, successor to the single-write, dual-read `reg_file`. It provides configurable width, depth and read/write port counts, and keeps `x0` hardwired to zero. A per-register busy scoreboard lets issue logic detect pending writebacks. An optional write-to-read bypass is also provided. It sits between decode/issue, which reads operands and marks destinations busy, and writeback, which writes results and clears busy bits.

## Interface
Parameters:
- `XLEN`, 32: data width in bits.
- `NREGS`, 32: number of architectural registers; power of two, ≥ 2.
- `NUM_RD`, 2: read ports, 1..4.
- `NUM_WR`, 1: write ports, 1..2.
- `AW`, derived `$clog2(NREGS)`: address width; not overridable.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rs_addr` in `NUM_RD*AW`: read addresses, port i at `[i*AW +: AW]`.
- `rs_data` out `NUM_RD*XLEN`: read data, combinational.
- `rs_busy` out `NUM_RD`: scoreboard bit of each read address.
- `we` in `NUM_WR`: write enables.
- `wr_addr` in `NUM_WR*AW`: write addresses.
- `wr_data` in `NUM_WR*XLEN`: write data.
- `wr_clr` in `NUM_WR`: clear busy bit of `wr_addr` on this write; qualified by `we`.
- `issue_valid` in 1: mark `issue_rd` busy.
- `issue_rd` in `AW`: destination being issued.
- `any_busy` out 1: OR of all busy bits.

## Operation
- Reset (async assert): all registers ← 0 and all busy bits ← 0. `rs_data` = 0, `rs_busy` = 0 and `any_busy` = 0 while `rst_n` is low. Deassertion is synchronised externally.
- Read: `rs_data[i]` = reg[`rs_addr[i]`], combinational, with no read-port conflicts. Address 0 always returns 0 and `rs_busy` = 0.
- Write: on the rising edge with `we[j]` = 1 and `wr_addr[j]` ≠ 0, reg ← `wr_data[j]`. Writes to address 0 are discarded, including their `wr_clr`.
- Same-address writes from two ports in one cycle: the higher port index wins for both data and clear.
- Scoreboard:
  - `issue_valid` with `issue_rd` ≠ 0 sets busy[`issue_rd`] at the edge.
  - `we[j]` & `wr_clr[j]` clears busy[`wr_addr[j]`] at the edge.
  - Set and clear on the same register in the same cycle: set wins, because a new producer supersedes the old one.
- Writes with `wr_clr` = 0 update data only; this supports non-final partial results.
- Setting an already-busy register keeps it busy, with no counting. Clearing a non-busy register is a no-op.

## Timing
- Read latency is 0 cycles from address to data.
- Write-to-read latency is 1 cycle without bypass: data written at edge N is visible on `rs_data` after edge N.
- `issue_valid` at edge N gives `rs_busy` = 1 after edge N.
- `wr_clr` at edge N gives `rs_busy` = 0 after edge N, unless bypassed (see Configuration).
- `any_busy` is registered-state derived and changes only after edges or reset.
- Reset asserted mid-cycle overrides any pending write or issue; nothing is committed at the next edge while `rst_n` = 0.

## Configuration
- Macro `REG_FILE_BYPASS_EN`.
- Defined: a read address matching an active write (`we[j]`, `wr_addr[j]` ≠ 0) returns `wr_data[j]` in the same cycle, with the highest matching port index winning. If that write also has `wr_clr`, `rs_busy` for that port reads 0 in the same cycle. A same-cycle `issue_valid` to that register still forces `rs_busy` to 1.
- Undefined: no forwarding; reads see only registered state, and `rs_busy` reflects only registered busy bits.

## Structure
- Package `reg_file_pkg` holds:
  - `XLEN_DEF` = 32 and `NREGS_DEF` = 32.
  - `REG_ZERO` = 0.
  - A `reg_addr_t` typedef at default width.
  - Function `port_slice`, the indexing helper.
- Sub-module `reg_file_scoreboard` holds the `NREGS`-bit busy vector with set/clear logic and the `any_busy` reduction. The top level instantiates it alongside the storage array and read muxes.

## Test plan
1. Reset → write 42 to x1 and 7 to x2 on port 0 → next cycle, reading x1/x2 gives 42/7 and x3 gives 0.
2. Write 999 to x0 with `wr_clr` = 1 and `issue_rd` = 0 → x0 reads 0, `rs_busy` = 0, `any_busy` = 0.
3. With `NUM_WR` = 2, both ports write x5 in the same cycle (0x11 on port 0, 0x22 on port 1) → x5 = 0x22.
4. Issue x6 → `rs_busy` = 1 and `any_busy` = 1. In the same cycle, write x6 with `wr_clr` and re-issue x6 → stays busy. Next cycle, write x6 with `wr_clr` and no issue → busy clears.
5. `REG_FILE_BYPASS_EN` defined: write 0xABCD to x9 while reading x9 → `rs_data` = 0xABCD in the same cycle. Undefined: the old value is returned until the next cycle.
6. Assert `rst_n` low mid-cycle after writing x1 = 5 and issuing x4 → x1 reads 0 immediately, `any_busy` = 0, and a write asserted during reset is not committed.
